// File: rtl/mod_ctrl_seq.sv
`default_nettype none
// ============================================================================
// mod_ctrl_seq -- shadow/active modulator control sequencer; commits on sample
// boundaries and flushes the datapath on structural changes.   Rev 1.0
// ============================================================================
module mod_ctrl_seq #(
  parameter int DIV   = 16,
  parameter int FLUSH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_addr_i,
  input  logic [23:0] wr_data_i,
  input  logic        commit_i,
  output logic        val_smp_o,
  output logic [23:0] frec_mod_o,
  output logic [23:0] frec_por_o,
  output logic [15:0] im_am_o,
  output logic [15:0] im_fm_o,
  output logic        c_fm_am_o,
  output logic [1:0]  c_source_o,
  output logic        c_comp_dac_o,
  output logic        dp_rst_o,
  output logic        mute_o,
  output logic        busy_o,
  output logic        commit_drop_o
);

  localparam logic [1:0]  c_IDLE     = 2'd0;
  localparam logic [1:0]  c_WAIT_SMP = 2'd1;
  localparam logic [1:0]  c_APPLY    = 2'd2;
  localparam logic [1:0]  c_FLUSH    = 2'd3;
  localparam logic [15:0] c_DIV_LAST   = 16'(DIV - 1);
  localparam logic [7:0]  c_FLUSH_LAST = 8'(FLUSH - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;

  logic [23:0] sh_frec_mod_q, sh_frec_por_q;
  logic [15:0] sh_im_am_q, sh_im_fm_q;
  logic [3:0]  sh_ctrl_q;

  logic [23:0] act_frec_mod_q, act_frec_por_q;
  logic [15:0] act_im_am_q, act_im_fm_q;
  logic        act_fm_am_q;
  logic [1:0]  act_source_q;
  logic        act_comp_dac_q;

  logic        dp_rst_q, commit_drop_q;

  logic        w_val_smp;
  logic        w_struct_chg;
  logic        w_busy, w_mute, w_apply;

  assign cnt_d     = w_val_smp ? 16'd0 : cnt_q + 16'd1;
  assign w_val_smp = (cnt_q == c_DIV_LAST);

  // A change of modulation type or source invalidates the datapath history.
  assign w_struct_chg = (sh_ctrl_q[0] != act_fm_am_q) || (sh_ctrl_q[2:1] != act_source_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c_IDLE;
      cnt_q       <= 16'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = 8'd0;
    case (state_q)
      c_IDLE:     if (commit_i) state_d = c_WAIT_SMP;
      c_WAIT_SMP: if (w_val_smp) state_d = c_APPLY;
      c_APPLY:    state_d = w_struct_chg ? c_FLUSH : c_IDLE;
      c_FLUSH: begin
        flush_cnt_d = flush_cnt_q;
        if (w_val_smp) begin
          if (flush_cnt_q == c_FLUSH_LAST) begin
            state_d     = c_IDLE;
            flush_cnt_d = 8'd0;
          end else begin
            flush_cnt_d = flush_cnt_q + 8'd1;
          end
        end
      end
      default:    state_d = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (state_q != c_IDLE);
    w_mute  = (state_q == c_FLUSH);
    w_apply = (state_q == c_APPLY);
  end

  // Shadow writes land regardless of state; APPLY samples the pre-write value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_frec_mod_q  <= 24'd0;
      sh_frec_por_q  <= 24'd0;
      sh_im_am_q     <= 16'd0;
      sh_im_fm_q     <= 16'd0;
      sh_ctrl_q      <= 4'd0;
      act_frec_mod_q <= 24'd0;
      act_frec_por_q <= 24'd0;
      act_im_am_q    <= 16'd0;
      act_im_fm_q    <= 16'd0;
      act_fm_am_q    <= 1'b0;
      act_source_q   <= 2'd0;
      act_comp_dac_q <= 1'b0;
      dp_rst_q       <= 1'b0;
      commit_drop_q  <= 1'b0;
    end else begin
      if (wr_en_i) begin
        case (wr_addr_i)
          3'd0:    sh_frec_mod_q <= wr_data_i;
          3'd1:    sh_frec_por_q <= wr_data_i;
          3'd2:    sh_im_am_q    <= wr_data_i[15:0];
          3'd3:    sh_im_fm_q    <= wr_data_i[15:0];
          3'd4:    sh_ctrl_q     <= wr_data_i[3:0];
          default: ;
        endcase
      end
      if (w_apply) begin
        act_frec_mod_q <= sh_frec_mod_q;
        act_frec_por_q <= sh_frec_por_q;
        act_im_am_q    <= sh_im_am_q;
        act_im_fm_q    <= sh_im_fm_q;
        act_fm_am_q    <= sh_ctrl_q[0];
        act_source_q   <= sh_ctrl_q[2:1];
        act_comp_dac_q <= sh_ctrl_q[3];
      end
      dp_rst_q      <= w_apply & w_struct_chg;
      commit_drop_q <= commit_i & w_busy;
    end
  end

  assign val_smp_o     = w_val_smp;
  assign frec_mod_o    = act_frec_mod_q;
  assign frec_por_o    = act_frec_por_q;
  assign im_am_o       = act_im_am_q;
  assign im_fm_o       = act_im_fm_q;
  assign c_fm_am_o     = act_fm_am_q;
  assign c_source_o    = act_source_q;
  assign c_comp_dac_o  = act_comp_dac_q;
  assign dp_rst_o      = dp_rst_q;
  assign mute_o        = w_mute;
  assign busy_o        = w_busy;
  assign commit_drop_o = commit_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_ctrl_seq.sv
`default_nettype none
// ============================================================================
// tb_mod_ctrl_seq -- directed + random bench with a timeline reference model.
// Rev 1.0
// ============================================================================
module tb_mod_ctrl_seq;

  localparam int DIV   = 4;
  localparam int FLUSH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [23:0] wr_data = 24'd0;
  logic        commit = 1'b0;
  logic        val_smp, c_fm_am, c_comp_dac, dp_rst, mute, busy, commit_drop;
  logic [23:0] frec_mod, frec_por;
  logic [15:0] im_am, im_fm;
  logic [1:0]  c_source;

  mod_ctrl_seq #(.DIV(DIV), .FLUSH(FLUSH)) dut (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .commit_i(commit),
    .val_smp_o(val_smp), .frec_mod_o(frec_mod), .frec_por_o(frec_por),
    .im_am_o(im_am), .im_fm_o(im_fm), .c_fm_am_o(c_fm_am), .c_source_o(c_source),
    .c_comp_dac_o(c_comp_dac), .dp_rst_o(dp_rst), .mute_o(mute), .busy_o(busy),
    .commit_drop_o(commit_drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: cycle index since reset release plus event deadlines.
  int t, busy_end, apply_at, mute_lo, mute_hi, drop_at;
  logic [23:0] sh_mod, sh_por, ac_mod, ac_por;
  logic [15:0] sh_am, sh_fm, ac_am, ac_fm;
  logic [3:0]  sh_ctl, ac_ctl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {59'd0, val_smp, dp_rst, mute, busy, commit_drop}, 64'd0);
    chk({tag, "_frec"}, {16'd0, frec_mod, frec_por}, 64'd0);
    chk({tag, "_idx"}, {28'd0, im_am, im_fm, c_comp_dac, c_source, c_fm_am}, 64'd0);
  endtask

  task automatic model_reset();
    t = 0; busy_end = -1; apply_at = -1; mute_lo = -1; mute_hi = -2; drop_at = -1;
    sh_mod = '0; sh_por = '0; sh_am = '0; sh_fm = '0; sh_ctl = '0;
    ac_mod = '0; ac_por = '0; ac_am = '0; ac_fm = '0; ac_ctl = '0;
  endtask

  task automatic check_cycle();
    chk("val_smp", {63'd0, val_smp}, {63'd0, (t % DIV) == DIV - 1});
    chk("busy", {63'd0, busy}, {63'd0, t <= busy_end});
    chk("mute", {63'd0, mute}, {63'd0, (t >= mute_lo) && (t <= mute_hi)});
    chk("dp_rst", {63'd0, dp_rst}, {63'd0, t == mute_lo});
    chk("commit_drop", {63'd0, commit_drop}, {63'd0, t == drop_at});
    chk("frec", {16'd0, frec_mod, frec_por}, {16'd0, ac_mod, ac_por});
    chk("idx_ctl", {28'd0, im_am, im_fm, c_comp_dac, c_source, c_fm_am},
        {28'd0, ac_am, ac_fm, ac_ctl});
  endtask

  task automatic model_update(input bit cm, input bit we, input logic [2:0] a,
                              input logic [23:0] d);
    int s;
    if (t == apply_at) begin
      if (sh_ctl[2:0] != ac_ctl[2:0]) begin
        mute_lo  = t + 1;
        mute_hi  = (t - 1) + FLUSH * DIV;
        busy_end = mute_hi;
      end
      ac_mod = sh_mod; ac_por = sh_por; ac_am = sh_am; ac_fm = sh_fm; ac_ctl = sh_ctl;
      apply_at = -1;
    end
    if (cm) begin
      if (t > busy_end) begin
        s = t + 1;
        while ((s % DIV) != DIV - 1) s++;
        apply_at = s + 1;
        busy_end = s + 1;
      end else begin
        drop_at = t + 1;
      end
    end
    if (we) begin
      case (a)
        3'd0: sh_mod = d;
        3'd1: sh_por = d;
        3'd2: sh_am  = d[15:0];
        3'd3: sh_fm  = d[15:0];
        3'd4: sh_ctl = d[3:0];
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit cm, input bit we, input logic [2:0] a, input logic [23:0] d);
    check_cycle();
    commit = cm; wr_en = we; wr_addr = a; wr_data = d;
    model_update(cm, we, a, d);
    @(posedge clk); #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 24'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("in_reset");
    rst = 1'b0;
    model_reset();

    // Plain parameter update: commit in cycle 5 applies at strobe 7, visible in 9.
    step(1'b0, 1'b1, 3'd0, 24'h123456);
    idle(4);
    step(1'b1, 1'b0, 3'd0, 24'd0);
    chk("busy_c6", {63'd0, busy}, 64'd1);
    idle(3);
    chk("frec_mod_c9", {40'd0, frec_mod}, {40'd0, 24'h123456});

    // Structural change: fm_am=1, source=01 -> dp_rst, then 3-strobe flush.
    step(1'b0, 1'b1, 3'd4, 24'h000003);
    step(1'b1, 1'b0, 3'd0, 24'd0);
    idle(2);
    chk("dp_rst_c13", {61'd0, dp_rst, mute, busy}, {61'd0, 3'b111});
    chk("ctrl_c13", {61'd0, c_source, c_fm_am}, {61'd0, 3'b011});
    idle(3);
    step(1'b1, 1'b1, 3'd0, 24'hABCDEF);
    chk("drop_c17", {63'd0, commit_drop}, 64'd1);
    chk("frec_held_c17", {40'd0, frec_mod}, {40'd0, 24'h123456});
    idle(7);
    chk("flush_end_c24", {62'd0, mute, busy}, 64'd0);
    chk("frec_held_c24", {40'd0, frec_mod}, {40'd0, 24'h123456});

    // Commit on a strobe cycle (27) must wait for strobe 31.
    idle(3);
    chk("smp_c27", {63'd0, val_smp}, 64'd1);
    step(1'b1, 1'b0, 3'd0, 24'd0);
    idle(2);
    chk("no_early_apply_c30", {40'd0, frec_mod}, {40'd0, 24'h123456});
    idle(3);
    chk("late_apply_c33", {40'd0, frec_mod}, {40'd0, 24'hABCDEF});

    // Write during APPLY: old shadow is applied, new value waits.
    step(1'b0, 1'b1, 3'd2, 24'h001111);
    step(1'b1, 1'b0, 3'd0, 24'd0);
    idle(1);
    step(1'b0, 1'b1, 3'd2, 24'h002222);
    chk("apply_prewrite", {48'd0, im_am}, {48'd0, 16'h1111});
    step(1'b1, 1'b0, 3'd0, 24'd0);
    idle(3);
    chk("apply_next", {48'd0, im_am}, {48'd0, 16'h2222});

    // Reset in the middle of a flush.
    step(1'b0, 1'b1, 3'd4, 24'h000000);
    step(1'b1, 1'b0, 3'd0, 24'd0);
    idle(4);
    chk("mid_flush", {63'd0, mute}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(12);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)), 24'($urandom));
    end
    idle(2 * FLUSH * DIV);
    check_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
